// File: rtl/secded_codec_pipe_if.sv
// ---------------------------------------------------------------------------
// secded_codec_pipe_if
//   Stream bundle for the SECDED codec: one valid/ready input channel
//   (word + mode) and one valid/ready output channel (result + mode).
//
//   Parameter
//     R : Hamming parity bits; the word width is N = 2**R.
//
//   Signals
//     in_valid  / in_ready   input handshake
//     in_mode                0 = decode, 1 = encode
//     in_word   [N-1:0]      codeword (decode) or data in [K-1:0] (encode)
//     out_valid / out_ready  output handshake
//     out_mode               mode that travelled with the result
//     out_word  [N-1:0]      codeword (encode) or {dbl, sgl, 0.., data}
//
//   Modports
//     master : the producer/consumer around the codec
//     slave  : the codec itself
// ---------------------------------------------------------------------------
interface secded_codec_pipe_if #(
  parameter int R = 4
);
  localparam int N = 2 ** R;

  logic         in_valid;
  logic         in_ready;
  logic         in_mode;
  logic [N-1:0] in_word;

  logic         out_valid;
  logic         out_ready;
  logic         out_mode;
  logic [N-1:0] out_word;

  modport master (
    output in_valid, in_mode, in_word, out_ready,
    input  in_ready, out_valid, out_mode, out_word
  );

  modport slave (
    input  in_valid, in_mode, in_word, out_ready,
    output in_ready, out_valid, out_mode, out_word
  );
endinterface

// File: rtl/secded_codec_pipe.sv
// ---------------------------------------------------------------------------
// secded_codec_pipe
//   Two-stage pipelined Hamming SECDED encoder/decoder with saturating
//   error statistics.  Each accepted word is either encoded into an N-bit
//   codeword or decoded into corrected data plus single/double error flags.
//
//   Parameters
//     R  : Hamming parity bits (3..6).  N = 2**R, K = N-1-R data bits.
//     CW : statistics counter width.
//
//   Ports
//     clk        system clock, rising edge
//     reset      synchronous reset, active low
//     bus        stream bundle (slave side): input word/mode, output result
//     clr_cnt    synchronous clear of all counters (wins over increments)
//     cnt_words  decoded words delivered
//     cnt_single single errors corrected
//     cnt_double double errors detected
//
//   Codeword layout: bit 0 is overall parity, parity bit pk sits at each
//   power-of-two position, data fills the remaining positions in ascending
//   order starting with data[0] at position 3.
// ---------------------------------------------------------------------------
module secded_codec_pipe #(
  parameter int R  = 4,
  parameter int CW = 16
) (
  input  logic               clk,
  input  logic               reset,
  secded_codec_pipe_if.slave bus,
  input  logic               clr_cnt,
  output logic [CW-1:0]      cnt_words,
  output logic [CW-1:0]      cnt_single,
  output logic [CW-1:0]      cnt_double
);

  localparam int N = 2 ** R;
  localparam int K = N - 1 - R;

  if (R < 3 || R > 6) begin : g_bad_r
    $error("secded_codec_pipe: R must be in 3..6");
  end

  // -------------------------------------------------------------------------
  // Codeword helpers
  // -------------------------------------------------------------------------

  // Place data bits into the non-power-of-two positions; parity slots are 0.
  function automatic logic [N-1:0] scatter(input logic [K-1:0] d);
    logic [N-1:0] w;
    int           j;
    w = '0;
    j = 0;
    for (int i = 1; i < N; i++) begin
      if ((i & (i - 1)) != 0) begin
        w[i] = d[j];
        j++;
      end
    end
    return w;
  endfunction

  // Inverse of scatter: gather the data positions back into K bits.
  function automatic logic [K-1:0] gather(input logic [N-1:0] w);
    logic [K-1:0] d;
    int           j;
    d = '0;
    j = 0;
    for (int i = 1; i < N; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[j] = w[i];
        j++;
      end
    end
    return d;
  endfunction

  // XOR of the indices of all set bits in positions 1..N-1.
  function automatic logic [R-1:0] syndrome(input logic [N-1:0] w);
    logic [R-1:0] s;
    s = '0;
    for (int i = 1; i < N; i++) begin
      if (w[i]) s ^= R'(i);
    end
    return s;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  // -------------------------------------------------------------------------
  // Handshake: both stages advance together whenever the output slot is
  // free or being drained this cycle.
  // -------------------------------------------------------------------------
  logic en;
  logic out_valid_q;

  assign en           = !out_valid_q || bus.out_ready;
  assign bus.in_ready = en;

  // -------------------------------------------------------------------------
  // Stage 1: word, mode, syndrome and overall parity.
  // For encode the word is first scattered with zero parity slots; its
  // syndrome is then exactly the Hamming parity vector, so the same
  // register carries s (decode) or the parity vector (encode).
  // -------------------------------------------------------------------------
  logic         s1_valid_q;
  logic         s1_mode_q;
  logic [N-1:0] s1_word_d, s1_word_q;
  logic [R-1:0] s1_syn_d,  s1_syn_q;
  logic         s1_par_d,  s1_par_q;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here unconditionally); a missing assignment would infer a latch.
  always_comb begin
    s1_word_d = bus.in_mode ? scatter(bus.in_word[K-1:0]) : bus.in_word;
    s1_syn_d  = syndrome(s1_word_d);
    s1_par_d  = ^s1_word_d;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge value of its inputs, independent of block order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
    end else if (en) begin
      s1_valid_q <= bus.in_valid;
    end
  end

  // NOTE: the stage-1 payload is not reset; it is only ever consumed when
  // s1_valid_q is set, which is cleared by reset.
  always_ff @(posedge clk) begin
    if (en && bus.in_valid) begin
      s1_mode_q <= bus.in_mode;
      s1_word_q <= s1_word_d;
      s1_syn_q  <= s1_syn_d;
      s1_par_q  <= s1_par_d;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: finish the encode, or correct/flag the decode.
  // -------------------------------------------------------------------------
  logic [N-1:0] enc_word;
  logic [N-1:0] fixed_word;
  logic [N-1:0] dec_word;
  logic         dbl_err;
  logic         sgl_err;
  logic [N-1:0] out_word_d, out_word_q;
  logic         out_mode_q;

  always_comb begin
    // Encode: drop the parity vector into the power-of-two slots.  Overall
    // parity is the data parity (s1_par_q) combined with the parity bits.
    enc_word = s1_word_q;
    for (int k = 0; k < R; k++) begin
      enc_word[1 << k] = s1_syn_q[k];
    end
    enc_word[0] = s1_par_q ^ (^s1_syn_q);

    // Decode: an odd overall parity means one flipped bit; it sits at
    // position s, or in p0 when s is zero.  Even parity with a non-zero
    // syndrome is an uncorrectable double error and is passed through raw.
    sgl_err    = s1_par_q;
    dbl_err    = !s1_par_q && (s1_syn_q != '0);
    fixed_word = s1_word_q;
    if (sgl_err && (s1_syn_q != '0)) begin
      fixed_word[s1_syn_q] = ~fixed_word[s1_syn_q];
    end

    dec_word        = '0;
    dec_word[K-1:0] = gather(fixed_word);
    dec_word[N-1]   = dbl_err;
    dec_word[N-2]   = sgl_err;

    out_word_d = s1_mode_q ? enc_word : dec_word;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_mode_q  <= 1'b0;
      out_word_q  <= '0;
    end else if (en) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_mode_q <= s1_mode_q;
        out_word_q <= out_word_d;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_mode  = out_mode_q;
  assign bus.out_word  = out_word_q;

  // -------------------------------------------------------------------------
  // Statistics: only delivered decode results count; flags are read from
  // the registered result that is being transferred.
  // -------------------------------------------------------------------------
  logic          xfer_dec;
  logic [CW-1:0] words_d,  words_q;
  logic [CW-1:0] single_d, single_q;
  logic [CW-1:0] double_d, double_q;

  assign xfer_dec = out_valid_q && bus.out_ready && !out_mode_q;

  always_comb begin
    words_d  = words_q;
    single_d = single_q;
    double_d = double_q;
    if (clr_cnt) begin
      words_d  = '0;
      single_d = '0;
      double_d = '0;
    end else if (xfer_dec) begin
      words_d = sat_inc(words_q);
      if (out_word_q[N-2]) single_d = sat_inc(single_q);
      if (out_word_q[N-1]) double_d = sat_inc(double_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      words_q  <= '0;
      single_q <= '0;
      double_q <= '0;
    end else begin
      words_q  <= words_d;
      single_q <= single_d;
      double_q <= double_d;
    end
  end

  assign cnt_words  = words_q;
  assign cnt_single = single_q;
  assign cnt_double = double_q;

endmodule

// File: tb/tb_secded_codec_pipe.sv
// ---------------------------------------------------------------------------
// tb_secded_codec_pipe
//   Scoreboard bench for secded_codec_pipe.  Two instances: dut_a (R=4,
//   CW=16) and dut_b (R=5, CW=4).  Stimulus pushes the expected result,
//   computed by a reference model built from the codeword rules (decode by
//   nearest-codeword search), into a queue; one monitor per instance pops
//   and compares on every output transfer and also tracks the counters.
// ---------------------------------------------------------------------------
module tb_secded_codec_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, rst_b = 1'b0;
  logic clr_a = 1'b0, clr_b = 1'b0;
  logic [15:0] cw_a, cs_a, cd_a;
  logic [3:0]  cw_b, cs_b, cd_b;

  secded_codec_pipe_if #(.R(4)) bus_a ();
  secded_codec_pipe_if #(.R(5)) bus_b ();

  secded_codec_pipe #(.R(4), .CW(16)) dut_a (
    .clk(clk), .reset(rst_a), .bus(bus_a), .clr_cnt(clr_a),
    .cnt_words(cw_a), .cnt_single(cs_a), .cnt_double(cd_a)
  );

  secded_codec_pipe #(.R(5), .CW(4)) dut_b (
    .clk(clk), .reset(rst_b), .bus(bus_b), .clr_cnt(clr_b),
    .cnt_words(cw_b), .cnt_single(cs_b), .cnt_double(cd_b)
  );

  typedef struct {
    int          id;
    logic        mode;
    logic [63:0] word;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          exp_w[2], exp_s[2], exp_d[2];
  bit          prev_rst_low[2];
  bit          prev_stall[2];
  logic [63:0] prev_word[2];
  logic        prev_mode[2];
  bit          rand_bp = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ----------------------------- reference model ---------------------------
  function automatic bit is_pow2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  function automatic logic [63:0] ref_encode(input logic [63:0] d, input int r);
    int n, j, ones;
    logic [63:0] c;
    n = 1 << r; j = 0; c = '0;
    for (int p = 1; p < n; p++)
      if (!is_pow2(p)) begin c[p] = d[j]; j++; end
    for (int b = 0; b < r; b++) begin
      ones = 0;
      for (int p = 1; p < n; p++) if (((p >> b) & 1) == 1 && c[p]) ones++;
      c[1 << b] = (ones % 2) == 1;
    end
    ones = 0;
    for (int p = 1; p < n; p++) if (c[p]) ones++;
    c[0] = (ones % 2) == 1;
    return c;
  endfunction

  function automatic logic [63:0] ref_extract(input logic [63:0] c, input int r);
    int n, j;
    logic [63:0] d;
    n = 1 << r; j = 0; d = '0;
    for (int p = 1; p < n; p++)
      if (!is_pow2(p)) begin d[j] = c[p]; j++; end
    return d;
  endfunction

  function automatic bit is_codeword(input logic [63:0] c, input int r);
    return ref_encode(ref_extract(c, r), r) == c;
  endfunction

  // Nearest-codeword decode: distance 0 clean, distance 1 single, else double.
  function automatic logic [63:0] ref_decode(input logic [63:0] w, input int r);
    int n;
    logic [63:0] f;
    n = 1 << r;
    if (n < 64) w &= (64'd1 << n) - 1;
    if (is_codeword(w, r)) return ref_extract(w, r);
    for (int p = 0; p < n; p++) begin
      f = w ^ (64'd1 << p);
      if (is_codeword(f, r)) return ref_extract(f, r) | (64'd1 << (n - 2));
    end
    return ref_extract(w, r) | (64'd1 << (n - 1));
  endfunction

  function automatic logic [63:0] rand_cw(input int r, input int nf);
    int n, k, p1, p2;
    logic [63:0] d, c;
    n = 1 << r; k = n - 1 - r;
    d = {$urandom, $urandom};
    d &= (64'd1 << k) - 1;
    c = ref_encode(d, r);
    p1 = $urandom_range(0, n - 1);
    p2 = (p1 + $urandom_range(1, n - 1)) % n;
    if (nf >= 1) c[p1] = ~c[p1];
    if (nf >= 2) c[p2] = ~c[p2];
    return c;
  endfunction

  // ----------------------------- driver ------------------------------------
  task automatic drive(input int id, input logic v, input logic m, input logic [63:0] w);
    if (id == 0) begin bus_a.in_valid = v; bus_a.in_mode = m; bus_a.in_word = w[15:0]; end
    else         begin bus_b.in_valid = v; bus_b.in_mode = m; bus_b.in_word = w[31:0]; end
  endtask

  function automatic logic in_rdy(input int id);
    return (id == 0) ? bus_a.in_ready : bus_b.in_ready;
  endfunction

  function automatic int pending(input int id);
    int c = 0;
    foreach (sb[i]) if (sb[i].id == id) c++;
    return c;
  endfunction

  // Offer one word; push its expected result when it is actually taken.
  task automatic send(input int id, input logic m, input logic [63:0] w);
    int r, k;
    exp_t e;
    r = (id == 0) ? 4 : 5;
    k = (1 << r) - 1 - r;
    e.id = id; e.mode = m;
    e.word = m ? ref_encode(w & ((64'd1 << k) - 1), r) : ref_decode(w, r);
    drive(id, 1'b1, m, w);
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (in_rdy(id)) begin
        sb.push_back(e);
        @(posedge clk); #1;
        drive(id, 1'b0, 1'b0, '0);
        return;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    $display("FAIL send timeout id=%0d: in_ready stayed 0, expected 1", id);
    drive(id, 1'b0, 1'b0, '0);
  endtask

  task automatic drain(input int id);
    for (int t = 0; t < 2000 && pending(id) > 0; t++) @(negedge clk);
    if (pending(id) > 0) begin
      n_checks++;
      $display("FAIL drain timeout id=%0d: %0d results outstanding, expected 0", id, pending(id));
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ----------------------------- monitor -----------------------------------
  task automatic mon(input int id, input int r, input int cwb, input logic rst,
                     input logic vld, input logic rdy, input logic irdy, input logic mode,
                     input logic [63:0] word, input logic clr,
                     input logic [63:0] cw, input logic [63:0] cs, input logic [63:0] cd);
    int n, cmax, idx;
    string tag;
    exp_t e;
    n = 1 << r; cmax = (1 << cwb) - 1;
    tag = (id == 0) ? "r4" : "r5";
    if (prev_rst_low[id]) check({tag, " out_valid after reset"}, 64'(vld), 64'd0);
    if (!rst) begin
      for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].id == id) sb.delete(i);
      exp_w[id] = 0; exp_s[id] = 0; exp_d[id] = 0;
      prev_rst_low[id] = 1'b1;
      prev_stall[id]   = 1'b0;
      return;
    end
    prev_rst_low[id] = 1'b0;
    check({tag, " cnt_words"},  cw, 64'(exp_w[id]));
    check({tag, " cnt_single"}, cs, 64'(exp_s[id]));
    check({tag, " cnt_double"}, cd, 64'(exp_d[id]));
    check({tag, " in_ready"}, 64'(irdy), 64'(!vld || rdy));
    if (prev_stall[id]) begin
      check({tag, " stall out_word"}, word, prev_word[id]);
      check({tag, " stall out_mode"}, 64'(mode), 64'(prev_mode[id]));
    end
    if (vld && rdy) begin
      idx = -1;
      for (int i = 0; i < sb.size() && idx < 0; i++) if (sb[i].id == id) idx = i;
      if (idx < 0) begin
        n_checks++;
        $display("FAIL %s unexpected output: got 0x%0h, expected none", tag, word);
      end else begin
        e = sb[idx];
        sb.delete(idx);
        check({tag, " out_word"}, word, e.word);
        check({tag, " out_mode"}, 64'(mode), 64'(e.mode));
        if (!e.mode) begin
          if (exp_w[id] < cmax) exp_w[id]++;
          if (e.word[n-2] && exp_s[id] < cmax) exp_s[id]++;
          if (e.word[n-1] && exp_d[id] < cmax) exp_d[id]++;
        end
      end
    end
    if (clr) begin exp_w[id] = 0; exp_s[id] = 0; exp_d[id] = 0; end
    prev_stall[id] = vld && !rdy;
    prev_word[id]  = word;
    prev_mode[id]  = mode;
  endtask

  always @(negedge clk)
    mon(0, 4, 16, rst_a, bus_a.out_valid, bus_a.out_ready, bus_a.in_ready, bus_a.out_mode,
        64'(bus_a.out_word), clr_a, 64'(cw_a), 64'(cs_a), 64'(cd_a));

  always @(negedge clk)
    mon(1, 5, 4, rst_b, bus_b.out_valid, bus_b.out_ready, bus_b.in_ready, bus_b.out_mode,
        64'(bus_b.out_word), clr_b, 64'(cw_b), 64'(cs_b), 64'(cd_b));

  always @(posedge clk) begin
    #1;
    if (rand_bp) begin
      bus_a.out_ready = ($urandom_range(0, 3) != 0);
      bus_b.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic random_run(input int id, input int count);
    int r;
    r = (id == 0) ? 4 : 5;
    for (int i = 0; i < count; i++) begin
      if ($urandom_range(0, 3) == 0) send(id, 1'b1, {$urandom, $urandom});
      else send(id, 1'b0, rand_cw(r, $urandom_range(0, 2)));
      if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
    end
  endtask

  // ----------------------------- stimulus ----------------------------------
  initial begin
    int c;
    drive(0, 1'b0, 1'b0, '0);
    drive(1, 1'b0, 1'b0, '0);
    bus_a.out_ready = 1'b1;
    bus_b.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b1;
    @(negedge clk);
    check("r4 in_ready out of reset", 64'(bus_a.in_ready), 64'd1);
    check("r4 out_word out of reset", 64'(bus_a.out_word), 64'd0);
    @(posedge clk); #1;

    // Encode with latency measurement.
    send(0, 1'b1, 64'h07FF);
    c = 0;
    while (c < 10 && !bus_a.out_valid) begin @(negedge clk); c++; end
    check("r4 encode latency", 64'(c), 64'd2);
    @(posedge clk); #1;
    send(0, 1'b1, 64'h0000);

    // Clean, single (data bit and p0) decodes, then a double.
    send(0, 1'b0, 64'hFFFF);
    send(0, 1'b0, 64'h0020);
    send(0, 1'b0, 64'h0001);
    drain(0);
    check("r4 cnt_words after 3 decodes", 64'(cw_a), 64'd3);
    check("r4 cnt_single after 3 decodes", 64'(cs_a), 64'd2);
    send(0, 1'b0, 64'h0208);
    drain(0);
    check("r4 cnt_double after double", 64'(cd_a), 64'd1);

    // Back-to-back stream with a three-cycle output stall.
    fork
      begin
        for (int i = 0; i < 4; i++) send(0, 1'b0, rand_cw(4, i % 3));
      end
      begin
        @(posedge clk); @(posedge clk); #1;
        bus_a.out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("r4 in_ready during stall", 64'(bus_a.in_ready), 64'd0);
          @(posedge clk); #1;
        end
        bus_a.out_ready = 1'b1;
      end
    join
    drain(0);

    // Reset with two words in flight.
    bus_a.out_ready = 1'b0;
    send(0, 1'b0, rand_cw(4, 1));
    send(0, 1'b0, rand_cw(4, 0));
    rst_a = 1'b0;
    @(posedge clk); #1;
    rst_a = 1'b1;
    @(negedge clk);
    check("r4 out_valid after in-flight reset", 64'(bus_a.out_valid), 64'd0);
    check("r4 cnt_words after reset", 64'(cw_a), 64'd0);
    check("r4 in_ready after reset", 64'(bus_a.in_ready), 64'd1);
    @(posedge clk); #1;
    bus_a.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // Clear coincident with a decode transfer.
    send(0, 1'b0, rand_cw(4, 2));
    send(0, 1'b0, rand_cw(4, 1));
    drain(0);
    bus_a.out_ready = 1'b0;
    send(0, 1'b0, rand_cw(4, 1));
    c = 0;
    while (c < 10 && !bus_a.out_valid) begin @(negedge clk); c++; end
    @(posedge clk); #1;
    clr_a = 1'b1;
    bus_a.out_ready = 1'b1;
    @(posedge clk); #1;
    clr_a = 1'b0;
    @(negedge clk);
    check("r4 cnt_words after clear", 64'(cw_a), 64'd0);
    check("r4 cnt_single after clear", 64'(cs_a), 64'd0);
    check("r4 cnt_double after clear", 64'(cd_a), 64'd0);
    @(posedge clk); #1;

    // Random regression, R=4, random backpressure.
    rand_bp = 1'b1;
    random_run(0, 300);
    rand_bp = 1'b0;
    @(posedge clk); #2;
    bus_a.out_ready = 1'b1;
    drain(0);

    // R=5, CW=4: saturation, then random regression.
    rst_b = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) send(1, 1'b0, rand_cw(5, $urandom_range(0, 2)));
    drain(1);
    check("r5 cnt_words saturated", 64'(cw_b), 64'd15);
    rand_bp = 1'b1;
    random_run(1, 300);
    rand_bp = 1'b0;
    @(posedge clk); #2;
    bus_b.out_ready = 1'b1;
    drain(1);

    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard leftover: got %0d entries, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
